op_sequencer: RTL and testbench

- Replaces the externally driven count with a self-timed FSM that sequences the X/Y/Z register bank and the ALU for one arithmetic operation per request.
- Uses a start/busy/done handshake and drives the 2-bit register command codes (HOLD/LOAD/SHIFTR/RESET) and the 1-bit ALU select.
- Drives an operand-source select so the upstream mux presents operand A, then operand B.
- Sits between the command source (keypad/host logic) and the register/ALU datapath.

---
 rtl/op_sequencer_pkg.sv | 77 +++++++
 rtl/op_sequencer_shamt_counter.sv | 32 +++
 rtl/op_sequencer.sv | 134 +++++++++++++
 tb/tb_op_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/op_sequencer_pkg.sv
// Shared encodings for the operation sequencer: register/ALU command codes,
// opcodes, FSM states and the registered output bundle.
package op_sequencer_pkg;

    localparam logic [1:0] CMD_HOLD   = 2'b00;
    localparam logic [1:0] CMD_LOAD   = 2'b01;
    localparam logic [1:0] CMD_SHIFTR = 2'b10;
    localparam logic [1:0] CMD_RESET  = 2'b11;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_SUB    = 2'b01;
    localparam logic [1:0] OP_ADDSHR = 2'b10;
    localparam logic [1:0] OP_CLR    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LD_X  = 3'd1,
        ST_LD_Y  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_EXEC  = 3'd4,
        ST_CLEAR = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       opnd_sel;
        logic [1:0] tx;
        logic [1:0] ty;
        logic [1:0] tz;
        logic       tula;
    } seq_out_t;

    localparam seq_out_t OUT_IDLE = seq_out_t'(10'd0);

    // Output pattern presented while the FSM occupies a given state.
    function automatic seq_out_t decode_outputs(input state_t state, input logic [1:0] opcode);
        seq_out_t o;
        o.busy     = 1'b1;
        o.done     = 1'b0;
        o.opnd_sel = 1'b0;
        o.tx       = CMD_HOLD;
        o.ty       = CMD_HOLD;
        o.tz       = CMD_HOLD;
        o.tula     = ALU_ADD;
        case (state)
            ST_IDLE:  o.busy = 1'b0;
            ST_LD_X: begin
                o.tx = CMD_LOAD;
                o.ty = CMD_RESET;
                o.tz = CMD_RESET;
            end
            ST_LD_Y: begin
                o.ty       = CMD_LOAD;
                o.opnd_sel = 1'b1;
            end
            ST_SHIFT: o.ty = CMD_SHIFTR;
            ST_EXEC: begin
                o.tz   = CMD_LOAD;
                o.tula = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
            end
            ST_CLEAR: begin
                o.tx = CMD_RESET;
                o.ty = CMD_RESET;
                o.tz = CMD_RESET;
            end
            ST_DONE:  o.done = 1'b1;
            default:  o.busy = 1'b0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/op_sequencer_shamt_counter.sv
// Loadable down-counter timing the SHIFT state; saturates at zero so it can
// never wrap, and flags zero to end the shift run.
module shamt_counter #(
    parameter int SHW = 3
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           load,
    input  logic           dec,
    input  logic [SHW-1:0] load_value,
    output logic           zero
);

    localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
    localparam logic [SHW-1:0] CNT_ONE  = CNT_ZERO + 1'b1;

    logic [SHW-1:0] count_r;

    // Count register: load has priority, decrement stops at zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= CNT_ZERO;
        end else if (load) begin
            count_r <= load_value;
        end else if (dec && (count_r != CNT_ZERO)) begin
            count_r <= count_r - CNT_ONE;
        end
    end

    assign zero = (count_r == CNT_ZERO);

endmodule

// File: rtl/op_sequencer.sv
// Self-timed sequencer driving the X/Y/Z register bank and ALU for one
// arithmetic operation per start request.
module op_sequencer
    import op_sequencer_pkg::*;
#(
    parameter int SHW = 3
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           start,
    input  logic [1:0]     opcode,
    input  logic [SHW-1:0] shamt,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    output logic           opnd_sel,
    output logic [1:0]     Tx,
    output logic [1:0]     Ty,
    output logic [1:0]     Tz,
    output logic           Tula
);

    localparam logic [SHW-1:0] SH_ZERO = {SHW{1'b0}};
    localparam logic [SHW-1:0] SH_ONE  = SH_ZERO + 1'b1;

    state_t         state_r;
    state_t         next_s;
    seq_out_t       out_r;
    seq_out_t       out_next_s;
    logic [1:0]     opcode_r;
    logic [SHW-1:0] shamt_r;
    logic           accept_s;
    logic           cnt_load_s;
    logic           cnt_dec_s;
    logic           cnt_zero_s;
    logic [SHW-1:0] cnt_value_s;

    // Counter is preloaded with shamt-1 so its zero flag marks the final SHIFT cycle.
    shamt_counter #(.SHW(SHW)) u_shamt_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (cnt_load_s),
        .dec        (cnt_dec_s),
        .load_value (cnt_value_s),
        .zero       (cnt_zero_s)
    );

    // Next-state logic; abort overrides the normal step in the working states.
    always_comb begin
        next_s      = ST_IDLE;
        accept_s    = 1'b0;
        cnt_load_s  = 1'b0;
        cnt_dec_s   = 1'b0;
        cnt_value_s = shamt_r - SH_ONE;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    next_s   = (opcode == OP_CLR) ? ST_CLEAR : ST_LD_X;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_LD_X: begin
                if (abort) begin
                    next_s = ST_CLEAR;
                end else begin
                    next_s = ST_LD_Y;
                end
            end
            ST_LD_Y: begin
                if (abort) begin
                    next_s = ST_CLEAR;
                end else if ((opcode_r == OP_ADDSHR) && (shamt_r != SH_ZERO)) begin
                    next_s     = ST_SHIFT;
                    cnt_load_s = 1'b1;
                end else begin
                    next_s = ST_EXEC;
                end
            end
            ST_SHIFT: begin
                cnt_dec_s = 1'b1;
                if (abort) begin
                    next_s = ST_CLEAR;
                end else if (cnt_zero_s) begin
                    next_s = ST_EXEC;
                end else begin
                    next_s = ST_SHIFT;
                end
            end
            ST_EXEC: begin
                if (abort) begin
                    next_s = ST_CLEAR;
                end else begin
                    next_s = ST_DONE;
                end
            end
            ST_CLEAR: next_s = ST_DONE;
            ST_DONE:  next_s = ST_IDLE;
            default:  next_s = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        out_next_s = decode_outputs(next_s, opcode_r);
    end

    // State, registered outputs and captured request fields.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            out_r    <= OUT_IDLE;
            opcode_r <= OP_ADD;
            shamt_r  <= SH_ZERO;
        end else begin
            state_r <= next_s;
            out_r   <= out_next_s;
            if (accept_s) begin
                opcode_r <= opcode;
                shamt_r  <= shamt;
            end
        end
    end

    assign busy     = out_r.busy;
    assign done     = out_r.done;
    assign opnd_sel = out_r.opnd_sel;
    assign Tx       = out_r.tx;
    assign Ty       = out_r.ty;
    assign Tz       = out_r.tz;
    assign Tula     = out_r.tula;

endmodule

// File: tb/tb_op_sequencer.sv
// Bench for op_sequencer: per-cycle trace model plus a small X/Y/Z datapath
// driven by the sequencer commands, with hand-computed latency and result checks.
module tb_op_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] opcode = 2'b00;
    logic [2:0] shamt = 3'd0;
    logic       busy, done, opnd_sel, Tula;
    logic [1:0] Tx, Ty, Tz;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    op_sequencer #(.SHW(3)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .opcode   (opcode),
        .shamt    (shamt),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .opnd_sel (opnd_sel),
        .Tx       (Tx),
        .Ty       (Ty),
        .Tz       (Tz),
        .Tula     (Tula)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs per cycle: {busy,done,opnd_sel,Tx,Ty,Tz,Tula}
    typedef struct packed {
        logic [9:0] vec;
        logic       abortable;
    } step_t;

    localparam logic [9:0] V_LDX   = {1'b1, 1'b0, 1'b0, 2'b01, 2'b11, 2'b11, 1'b0};
    localparam logic [9:0] V_LDY   = {1'b1, 1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 1'b0};
    localparam logic [9:0] V_SHIFT = {1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [9:0] V_ADD   = {1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0};
    localparam logic [9:0] V_SUB   = {1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b1};
    localparam logic [9:0] V_CLEAR = {1'b1, 1'b0, 1'b0, 2'b11, 2'b11, 2'b11, 1'b0};
    localparam logic [9:0] V_DONE  = {1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};

    step_t exp_q[$];
    step_t cur;
    logic  cur_valid = 1'b0;

    // Trace model: on acceptance, queue the whole per-cycle output sequence of the request.
    initial begin
        forever begin
            @(posedge clock or negedge reset_n);
            if (reset_n !== 1'b1) begin
                exp_q.delete();
                cur_valid = 1'b0;
            end else begin
                if (cur_valid && cur.abortable && abort) begin
                    exp_q.delete();
                    exp_q.push_back('{V_CLEAR, 1'b0});
                    exp_q.push_back('{V_DONE, 1'b0});
                end else if (!cur_valid && start) begin
                    if (opcode == 2'b11) begin
                        exp_q.push_back('{V_CLEAR, 1'b0});
                    end else begin
                        exp_q.push_back('{V_LDX, 1'b1});
                        exp_q.push_back('{V_LDY, 1'b1});
                        if (opcode == 2'b10) begin
                            for (int i = 0; i < int'(shamt); i++) exp_q.push_back('{V_SHIFT, 1'b1});
                        end
                        exp_q.push_back('{(opcode == 2'b01) ? V_SUB : V_ADD, 1'b1});
                    end
                    exp_q.push_back('{V_DONE, 1'b0});
                end
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    cur_valid = 1'b1;
                end else begin
                    cur_valid = 1'b0;
                end
            end
        end
    end

    // Compare the DUT outputs with the trace model on every falling edge out of reset.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1)
                check("outputs", {busy, done, opnd_sel, Tx, Ty, Tz, Tula}, cur_valid ? cur.vec : 10'd0);
        end
    end

    // Register bank driven by the sequencer commands.
    logic [7:0] opa = 8'd0, opb = 8'd0;
    logic [7:0] x_r, y_r, z_r;
    logic [7:0] bus_s;
    assign bus_s = opnd_sel ? opb : opa;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_r <= 8'd0;
            y_r <= 8'd0;
            z_r <= 8'd0;
        end else begin
            case (Tx)
                2'b01:   x_r <= bus_s;
                2'b11:   x_r <= 8'd0;
                default: x_r <= x_r;
            endcase
            case (Ty)
                2'b01:   y_r <= bus_s;
                2'b10:   y_r <= y_r >> 1;
                2'b11:   y_r <= 8'd0;
                default: y_r <= y_r;
            endcase
            case (Tz)
                2'b01:   z_r <= Tula ? (x_r - y_r) : (x_r + y_r);
                2'b11:   z_r <= 8'd0;
                default: z_r <= z_r;
            endcase
        end
    end

    task automatic run_op(input string name, input logic [1:0] op, input logic [2:0] sh,
                          input logic [7:0] a, input logic [7:0] b, input int abort_at,
                          input logic hold, input int exp_lat, input logic [7:0] exp_z,
                          input int exp_shifts, input int exp_loads);
        int n, lat, shifts, loads, w;
        w = 0;
        while (busy !== 1'b0 && w < 20) begin
            @(negedge clock); #1;
            w++;
        end
        opa = a;
        opb = b;
        start = 1'b1;
        opcode = op;
        shamt = sh;
        @(negedge clock); #1;
        if (hold) begin
            opcode = ~op;
            shamt = ~sh;
        end else begin
            start = 1'b0;
        end
        n = 1;
        lat = -1;
        shifts = 0;
        loads = 0;
        while (lat < 0 && n <= 40) begin
            if (Ty == 2'b10) shifts++;
            if (Tz == 2'b01) loads++;
            if (done === 1'b1) begin
                lat = n;
            end else begin
                abort = (n == abort_at);
                @(negedge clock); #1;
                n++;
            end
        end
        abort = 1'b0;
        start = 1'b0;
        check({name, "_done_seen"}, (lat >= 0), 1'b1);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_z"}, z_r, exp_z);
        check({name, "_shifts"}, shifts, exp_shifts);
        check({name, "_zloads"}, loads, exp_loads);
        @(negedge clock); #1;
        check({name, "_busy_after"}, busy, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check("reset_state", {busy, done, opnd_sel, Tx, Ty, Tz, Tula}, 10'd0);
        #1 reset_n = 1'b1;

        // abort while idle must be ignored
        @(negedge clock); #1 abort = 1'b1;
        @(negedge clock); #1 abort = 1'b0;

        run_op("add",      2'b00, 3'd0, 8'd20, 8'd22,  -1, 1'b0, 4,  8'd42, 0, 1);
        run_op("sub",      2'b01, 3'd0, 8'd9,  8'd3,   -1, 1'b0, 4,  8'd6,  0, 1);
        run_op("addshr3",  2'b10, 3'd3, 8'd5,  8'd40,  -1, 1'b0, 7,  8'd10, 3, 1);
        run_op("addshr0",  2'b10, 3'd0, 8'd5,  8'd40,  -1, 1'b0, 4,  8'd45, 0, 1);
        run_op("addshr7",  2'b10, 3'd7, 8'd5,  8'd200, -1, 1'b0, 11, 8'd6,  7, 1);
        run_op("abort_sh", 2'b10, 3'd5, 8'd5,  8'd40,  4,  1'b1, 6,  8'd0,  2, 0);
        run_op("abort_ex", 2'b00, 3'd0, 8'd1,  8'd1,   3,  1'b0, 5,  8'd0,  0, 1);
        run_op("clr",      2'b11, 3'd0, 8'd7,  8'd7,   -1, 1'b1, 2,  8'd0,  0, 0);
        run_op("add2",     2'b00, 3'd0, 8'd100, 8'd55, -1, 1'b0, 4,  8'd155, 0, 1);

        // asynchronous reset in the middle of a shift run
        opa = 8'd5;
        opb = 8'd40;
        @(negedge clock); #1;
        start = 1'b1;
        opcode = 2'b10;
        shamt = 3'd5;
        @(negedge clock); #1 start = 1'b0;
        repeat (3) begin
            @(negedge clock); #1;
        end
        check("pre_reset_shift", Ty, 2'b10);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset", {busy, done, opnd_sel, Tx, Ty, Tz, Tula}, 10'd0);
        @(negedge clock); #1 reset_n = 1'b1;

        run_op("post_reset", 2'b01, 3'd0, 8'd50, 8'd8, -1, 1'b0, 4, 8'd42, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
